// File: rtl/rs_lfsr_encoder.sv
// Systematic Reed-Solomon encoder over GF(2^8): K message symbols pass through, then NPAR parity symbols.
// Optional build macro RS_SHORTEN_EN adds s_last to end a message early (shortened codeword).
module rs_lfsr_encoder #(
    parameter int         K         = 239,
    parameter int         NPAR      = 16,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
`ifdef RS_SHORTEN_EN
    input  logic       s_last,
`endif
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_sof,
    output logic       m_eof,
    output logic       m_par
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] a;
        a = 8'h01;
        for (int n = 0; n < e; n++) a = gf_mul(a, 8'h02);
        return a;
    endfunction

    // Low NPAR coefficients of the monic generator; the x^NPAR term (1) is implicit.
    function automatic logic [8*NPAR-1:0] gen_poly();
        logic [7:0]        c [0:NPAR];
        logic [7:0]        root;
        logic [8*NPAR-1:0] packed_g;
        for (int j = 0; j <= NPAR; j++) c[j] = 8'h00;
        c[0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            root = alpha_pow((FCR + i) % 255);
            for (int j = NPAR; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
            c[0] = gf_mul(c[0], root);
        end
        packed_g = '0;
        for (int j = 0; j < NPAR; j++) packed_g[8*j +: 8] = c[j];
        return packed_g;
    endfunction

    localparam logic [8*NPAR-1:0] GEN = gen_poly();

    typedef enum logic {
        ST_MSG,
        ST_PAR
    } state_t;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic [7:0] r_reg    [NPAR];
    logic [7:0] msg_next [NPAR];
    logic [7:0] par_next [NPAR];
    logic [7:0] fb_term  [NPAR];
    logic [7:0] fb;
    logic       free;
    logic       msg_end;

    assign free    = !m_valid || m_ready;
    assign s_ready = (state_reg == ST_MSG) && free;
    assign fb      = s_data ^ r_reg[NPAR-1];

`ifdef RS_SHORTEN_EN
    assign msg_end = (cnt_reg == 8'(K - 1)) || s_last;
`else
    assign msg_end = (cnt_reg == 8'(K - 1));
`endif

    // Constant-coefficient multipliers collapse to XOR networks; stage next values for both states.
    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_stage
            assign fb_term[gi] = gf_mul(fb, GEN[8*gi +: 8]);
            if (gi == 0) begin : g_first
                assign msg_next[gi] = fb_term[gi];
                assign par_next[gi] = 8'h00;
            end else begin : g_rest
                assign msg_next[gi] = r_reg[gi-1] ^ fb_term[gi];
                assign par_next[gi] = r_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_MSG;
            cnt_reg   <= 8'h00;
            for (int i = 0; i < NPAR; i++) r_reg[i] <= 8'h00;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            m_par     <= 1'b0;
        end else if (free) begin
            if (state_reg == ST_MSG) begin
                if (s_valid) begin
                    for (int i = 0; i < NPAR; i++) r_reg[i] <= msg_next[i];
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    m_sof   <= (cnt_reg == 8'h00);
                    m_eof   <= 1'b0;
                    m_par   <= 1'b0;
                    if (msg_end) begin
                        cnt_reg   <= 8'h00;
                        state_reg <= ST_PAR;
                    end else begin
                        cnt_reg <= cnt_reg + 8'h01;
                    end
                end else begin
                    m_valid <= 1'b0;
                end
            end else begin
                // Shifting zeros in leaves the LFSR clear for the next codeword.
                for (int i = 0; i < NPAR; i++) r_reg[i] <= par_next[i];
                m_valid <= 1'b1;
                m_data  <= r_reg[NPAR-1];
                m_sof   <= 1'b0;
                m_eof   <= (cnt_reg == 8'(NPAR - 1));
                m_par   <= 1'b1;
                if (cnt_reg == 8'(NPAR - 1)) begin
                    cnt_reg   <= 8'h00;
                    state_reg <= ST_MSG;
                end else begin
                    cnt_reg <= cnt_reg + 8'h01;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_lfsr_encoder.sv
// Testbench for rs_lfsr_encoder: small K=3/NPAR=2 instance with directed vectors and a default
// RS(255,239) instance with random messages, checked against a polynomial-division reference model.
module tb_rs_lfsr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // small instance
    logic       sm_rst, sm_s_valid, sm_s_ready, sm_m_valid, sm_m_ready;
    logic       sm_m_sof, sm_m_eof, sm_m_par;
    logic [7:0] sm_s_data, sm_m_data;
    // default instance
    logic       df_rst, df_s_valid, df_s_ready, df_m_valid, df_m_ready;
    logic       df_m_sof, df_m_eof, df_m_par;
    logic [7:0] df_s_data, df_m_data;
`ifdef RS_SHORTEN_EN
    logic       sm_s_last, df_s_last;
`endif

    rs_lfsr_encoder #(.K(3), .NPAR(2), .PRIM_POLY(9'h11D), .FCR(0)) dut_sm (
        .clk(clk), .rst(sm_rst), .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_data(sm_s_data),
`ifdef RS_SHORTEN_EN
        .s_last(sm_s_last),
`endif
        .m_valid(sm_m_valid), .m_ready(sm_m_ready), .m_data(sm_m_data),
        .m_sof(sm_m_sof), .m_eof(sm_m_eof), .m_par(sm_m_par)
    );

    rs_lfsr_encoder dut_df (
        .clk(clk), .rst(df_rst), .s_valid(df_s_valid), .s_ready(df_s_ready), .s_data(df_s_data),
`ifdef RS_SHORTEN_EN
        .s_last(df_s_last),
`endif
        .m_valid(df_m_valid), .m_ready(df_m_ready), .m_data(df_m_data),
        .m_sof(df_m_sof), .m_eof(df_m_eof), .m_par(df_m_par)
    );

    // Words are {sof, eof, par, data}; small inputs are {last, data}.
    logic [8:0]  in_sm [$];
    logic [7:0]  in_df [$];
    logic [10:0] out_sm [$], exp_sm [$], out_df [$], exp_df [$];
    int          cyc_sm [$], cyc_df [$];
    logic [7:0]  msg_buf [$];
    int          gexp [0:254];
    int          glog [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // Parity = msg(x) * x^npar mod g(x), by long division over GF(256).
    task automatic model_cw(input int npar, input bit to_sm);
        int g [0:32];
        int buffer [0:300];
        int k, root, coef;
        logic [10:0] w;
        k = msg_buf.size();
        for (int j = 0; j <= 32; j++) g[j] = 0;
        g[0] = 1;
        for (int i = 0; i < npar; i++) begin
            root = gexp[i % 255];
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], root);
            g[0] = gmul(g[0], root);
        end
        for (int i = 0; i <= 300; i++) buffer[i] = 0;
        for (int i = 0; i < k; i++) buffer[i] = int'(msg_buf[i]);
        for (int i = 0; i < k; i++) begin
            coef = buffer[i];
            if (coef != 0)
                for (int j = 0; j <= npar; j++) buffer[i+j] = buffer[i+j] ^ gmul(g[npar-j], coef);
        end
        for (int i = 0; i < k; i++) begin
            w = {(i == 0), 1'b0, 1'b0, msg_buf[i]};
            if (to_sm) exp_sm.push_back(w); else exp_df.push_back(w);
        end
        for (int j = 0; j < npar; j++) begin
            w = {1'b0, (j == npar - 1), 1'b1, 8'(buffer[k+j])};
            if (to_sm) exp_sm.push_back(w); else exp_df.push_back(w);
        end
    endtask

    task automatic drive_sm(input int rdy_pct, input int n_out);
        int guard = 0;
        bit stalled = 1'b0;
        logic [11:0] held = '0;
        while ((in_sm.size() > 0 || out_sm.size() < n_out) && guard < 5000) begin
            @(negedge clk);
            sm_s_valid = (in_sm.size() > 0);
            sm_s_data  = (in_sm.size() > 0) ? in_sm[0][7:0] : 8'h00;
`ifdef RS_SHORTEN_EN
            sm_s_last  = (in_sm.size() > 0) ? in_sm[0][8] : 1'b0;
`endif
            sm_m_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (stalled) check("sm_hold", 32'({sm_m_valid, sm_m_sof, sm_m_eof, sm_m_par, sm_m_data}), 32'(held));
            if (sm_m_valid && !sm_m_ready) check("sm_bp_ready", 32'(sm_s_ready), 32'd0);
            stalled = sm_m_valid && !sm_m_ready;
            held = {sm_m_valid, sm_m_sof, sm_m_eof, sm_m_par, sm_m_data};
            if (sm_m_valid && sm_m_ready) begin
                out_sm.push_back({sm_m_sof, sm_m_eof, sm_m_par, sm_m_data});
                cyc_sm.push_back(cyc);
            end
            if (sm_s_valid && sm_s_ready) void'(in_sm.pop_front());
            guard++;
        end
        check("sm_timeout", 32'(guard < 5000), 32'd1);
    endtask

    task automatic drive_df(input int rdy_pct, input int n_out);
        int guard = 0;
        bit stalled = 1'b0;
        logic [11:0] held = '0;
        while ((in_df.size() > 0 || out_df.size() < n_out) && guard < 20000) begin
            @(negedge clk);
            df_s_valid = (in_df.size() > 0);
            df_s_data  = (in_df.size() > 0) ? in_df[0] : 8'h00;
            df_m_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (stalled) check("df_hold", 32'({df_m_valid, df_m_sof, df_m_eof, df_m_par, df_m_data}), 32'(held));
            if (df_m_valid && !df_m_ready) check("df_bp_ready", 32'(df_s_ready), 32'd0);
            stalled = df_m_valid && !df_m_ready;
            held = {df_m_valid, df_m_sof, df_m_eof, df_m_par, df_m_data};
            if (df_m_valid && df_m_ready) begin
                out_df.push_back({df_m_sof, df_m_eof, df_m_par, df_m_data});
                cyc_df.push_back(cyc);
            end
            if (df_s_valid && df_s_ready) void'(in_df.pop_front());
            guard++;
        end
        check("df_timeout", 32'(guard < 20000), 32'd1);
    endtask

    task automatic compare_sm(input string tag);
        check({tag, "_len"}, 32'(out_sm.size()), 32'(exp_sm.size()));
        for (int i = 0; i < exp_sm.size() && i < out_sm.size(); i++)
            check(tag, 32'(out_sm[i]), 32'(exp_sm[i]));
        $display("codeword %s: %0d symbols", tag, out_sm.size());
        out_sm.delete(); exp_sm.delete(); cyc_sm.delete();
    endtask

    task automatic compare_df(input string tag);
        check({tag, "_len"}, 32'(out_df.size()), 32'(exp_df.size()));
        for (int i = 0; i < exp_df.size() && i < out_df.size(); i++)
            check(tag, 32'(out_df[i]), 32'(exp_df[i]));
        $display("codeword %s: %0d symbols", tag, out_df.size());
        out_df.delete(); exp_df.delete(); cyc_df.delete();
    endtask

    task automatic rand_df_cw();
        msg_buf.delete();
        for (int i = 0; i < 239; i++) msg_buf.push_back(8'($urandom_range(255)));
        foreach (msg_buf[i]) in_df.push_back(msg_buf[i]);
        model_cw(16, 1'b0);
    endtask

    initial begin
        int x;
        logic [10:0] tab [10];
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        glog[0] = 0;

        sm_rst = 1'b0; sm_s_valid = 1'b0; sm_s_data = 8'h00; sm_m_ready = 1'b1;
        df_rst = 1'b0; df_s_valid = 1'b0; df_s_data = 8'h00; df_m_ready = 1'b1;
`ifdef RS_SHORTEN_EN
        sm_s_last = 1'b0; df_s_last = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", 32'(sm_m_valid), 32'd0);
        check("rst_m_data", 32'(sm_m_data), 32'd0);
        check("rst_flags", 32'({sm_m_sof, sm_m_eof, sm_m_par}), 32'd0);
        check("rst_s_ready", 32'(sm_s_ready), 32'd1);
        check("rst_df_m_valid", 32'(df_m_valid), 32'd0);
        sm_rst = 1'b1;
        df_rst = 1'b1;

        // Known vector 01,00,00 then an all-zero codeword, back to back.
        tab = '{11'h401, 11'h000, 11'h000, 11'h10F, 11'h30E,
                11'h400, 11'h000, 11'h000, 11'h100, 11'h300};
        foreach (tab[i]) exp_sm.push_back(tab[i]);
        in_sm.push_back(9'h001); in_sm.push_back(9'h000); in_sm.push_back(9'h000);
        repeat (3) in_sm.push_back(9'h000);
        drive_sm(100, 10);
        check("sm_nogap", 32'(cyc_sm[cyc_sm.size()-1] - cyc_sm[0]), 32'd9);
        compare_sm("sm_vec");

        // Random small codewords under 50% backpressure.
        for (int c = 0; c < 4; c++) begin
            msg_buf.delete();
            for (int i = 0; i < 3; i++) msg_buf.push_back(8'($urandom_range(255)));
            foreach (msg_buf[i]) in_sm.push_back({1'b0, msg_buf[i]});
            model_cw(2, 1'b1);
        end
        drive_sm(50, 20);
        compare_sm("sm_bp");

`ifdef RS_SHORTEN_EN
        exp_sm.push_back(11'h401); exp_sm.push_back(11'h103); exp_sm.push_back(11'h302);
        in_sm.push_back(9'h101);
        drive_sm(100, 3);
        compare_sm("sm_short");
`endif

        // Default code: three back-to-back random codewords at full rate.
        for (int c = 0; c < 3; c++) rand_df_cw();
        drive_df(100, 3 * 255);
        check("df_tput", 32'(cyc_df[cyc_df.size()-1] - cyc_df[0]), 32'(3 * 255 - 1));
        compare_df("df_full");

        // Random backpressure.
        for (int c = 0; c < 2; c++) rand_df_cw();
        drive_df(50, 2 * 255);
        compare_df("df_bp");

        // Reset after 100 message symbols, then a clean codeword.
        for (int i = 0; i < 100; i++) in_df.push_back(8'($urandom_range(255)));
        drive_df(100, 0);
        @(negedge clk);
        df_rst = 1'b0; df_s_valid = 1'b0; df_m_ready = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_m_valid", 32'(df_m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(df_s_ready), 32'd1);
        check("mid_rst_m_data", 32'(df_m_data), 32'd0);
        df_rst = 1'b1;
        out_df.delete(); cyc_df.delete();
        rand_df_cw();
        drive_df(100, 255);
        compare_df("df_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
